// File: rtl/riscboy_ppu_sprite_agu_rr.sv
// Sprite address-generation unit: round-robin coordinate queries and pixel fetches
// for N_SPRITE sprite pipelines, with per-sprite tile size and X/Y flip.
module riscboy_ppu_sprite_agu_rr #(
  parameter int                W_DATA     = 32,
  parameter int                W_ADDR     = 32,
  parameter int                W_COORD    = 9,
  parameter int                N_SPRITE   = 8,
  parameter logic [W_ADDR-1:0] ADDR_MASK  = '1,
  parameter int                W_SHIFTCTR = $clog2(W_DATA)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [W_COORD-1:0]      beam_x,
  input  logic [W_COORD-1:0]      beam_y,
  input  logic [N_SPRITE*W_COORD-1:0] cfg_sprite_pos_x,
  input  logic [N_SPRITE*W_COORD-1:0] cfg_sprite_pos_y,
  input  logic [N_SPRITE*8-1:0]   cfg_sprite_tile,
  input  logic [N_SPRITE-1:0]     cfg_sprite_tilesize,
  input  logic [N_SPRITE*2-1:0]   cfg_sprite_flip,
  input  logic [23:0]             cfg_sprite_tsbase,
  input  logic [2:0]              cfg_sprite_pixmode,
  input  logic [N_SPRITE-1:0]     sprite_req,
  output logic [N_SPRITE-1:0]     sprite_ack,
  output logic                    sprite_active,
  output logic [W_COORD-1:0]      sprite_x_count,
  output logic                    sprite_must_seek,
  output logic [W_SHIFTCTR-1:0]   sprite_shift_seek_target,
  input  logic [N_SPRITE-1:0]     sprite_bus_vld,
  output logic [N_SPRITE-1:0]     sprite_bus_rdy,
  input  logic [N_SPRITE*5-1:0]   sprite_bus_postcount,
  output logic [W_DATA-1:0]       sprite_bus_data,
  output logic                    bus_vld,
  output logic [W_ADDR-1:0]       bus_addr,
  output logic [1:0]              bus_size,
  input  logic                    bus_rdy,
  input  logic [W_DATA-1:0]       bus_data
);

  localparam int W_IDX = $clog2(N_SPRITE);
  localparam logic [W_ADDR-1:0] ALIGN_MASK = ~W_ADDR'(W_DATA / 8 - 1);

  typedef enum logic {IDLE, REQ} fetch_state_t;

  // Lowest eligible index at or after ptr, wrapping; MSB of the result flags a grant.
  function automatic logic [W_IDX:0] rr_pick(input logic [N_SPRITE-1:0] elig,
                                             input logic [W_IDX-1:0]    ptr);
    logic [W_IDX:0] r;
    int j;
    r = '0;
    for (int i = N_SPRITE - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N_SPRITE) j = j - N_SPRITE;
      if (elig[j]) r = {1'b1, W_IDX'(j)};
    end
    return r;
  endfunction

  function automatic logic [W_IDX-1:0] ptr_after(input logic [W_IDX-1:0] idx);
    return (int'(idx) == N_SPRITE - 1) ? '0 : idx + 1'b1;
  endfunction

  function automatic logic [2:0] mode_log_pixsize(input logic [2:0] mode);
    case (mode)
      3'd0:    return 3'd4; // ARGB1555
      3'd1:    return 3'd3; // PAL8
      3'd2:    return 3'd2; // PAL4
      default: return 3'd0; // PAL1
    endcase
  endfunction

  logic [2:0] log_pix;
  assign log_pix  = mode_log_pixsize(cfg_sprite_pixmode);
  assign bus_size = 2'($clog2(W_DATA / 8));

  // ---------------- Coordinate port ----------------
  logic [W_IDX-1:0]   ptr_c;
  logic [W_IDX:0]     c_pick;
  logic               c_grant;
  logic [W_IDX-1:0]   c_idx;
  logic [W_COORD-1:0] c_pos_x, c_pos_y;
  logic               c_ts16;
  logic [W_COORD:0]   c_ts, bx, by, px, py;
  logic               c_active, c_must_seek;
  logic [W_COORD-1:0] c_x_count;
  logic [W_SHIFTCTR-1:0] c_seek;

  assign c_pick  = rr_pick(sprite_req & ~sprite_ack, ptr_c);
  assign c_grant = c_pick[W_IDX];
  assign c_idx   = c_pick[W_IDX-1:0];
  assign c_pos_x = cfg_sprite_pos_x[c_idx*W_COORD +: W_COORD];
  assign c_pos_y = cfg_sprite_pos_y[c_idx*W_COORD +: W_COORD];
  assign c_ts16  = cfg_sprite_tilesize[c_idx];

  // Compare one bit wider than the coordinates so beam + tile size cannot wrap.
  assign c_ts = c_ts16 ? (W_COORD+1)'(16) : (W_COORD+1)'(8);
  assign bx   = {1'b0, beam_x};
  assign by   = {1'b0, beam_y};
  assign px   = {1'b0, c_pos_x};
  assign py   = {1'b0, c_pos_y};

  assign c_active    = (by < py) && (by + c_ts >= py) && (bx < px);
  assign c_x_count   = (bx < px) ? c_pos_x - beam_x : '0;
  assign c_must_seek = (bx + c_ts >= px);
  assign c_seek      = (W_SHIFTCTR'(c_ts16 ? 5'd16 : 5'd8) - W_SHIFTCTR'(c_x_count[4:0])) << log_pix;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_c                    <= '0;
      sprite_ack               <= '0;
      sprite_active            <= 1'b0;
      sprite_x_count           <= '0;
      sprite_must_seek         <= 1'b0;
      sprite_shift_seek_target <= '0;
    end else begin
      sprite_ack <= '0;
      if (c_grant) begin
        ptr_c                    <= ptr_after(c_idx);
        sprite_ack               <= N_SPRITE'(1) << c_idx;
        sprite_active            <= c_active;
        sprite_x_count           <= c_x_count;
        sprite_must_seek         <= c_must_seek;
        sprite_shift_seek_target <= c_seek;
      end
    end
  end

  // ---------------- Fetch port ----------------
  fetch_state_t       state, state_next;
  logic [N_SPRITE-1:0] grant_oh;
  logic [W_IDX-1:0]   ptr_b;
  logic [W_IDX:0]     b_pick;
  logic               b_grant, b_load;
  logic [W_IDX-1:0]   b_idx;
  logic               b_ts16;
  logic [1:0]         b_flip;
  logic [3:0]         b_u, b_v;
  logic [15:0]        b_tidx;
  logic [31:0]        b_byte_addr;
  logic [W_ADDR-1:0]  b_addr;

  assign bus_vld         = (state == REQ);
  assign sprite_bus_rdy  = bus_vld ? grant_oh & {N_SPRITE{bus_rdy}} : '0;
  assign sprite_bus_data = bus_data;

  assign b_pick  = rr_pick(sprite_bus_vld & ~sprite_bus_rdy, ptr_b);
  assign b_grant = b_pick[W_IDX];
  assign b_idx   = b_pick[W_IDX-1:0];
  assign b_ts16  = cfg_sprite_tilesize[b_idx];
  assign b_flip  = cfg_sprite_flip[b_idx*2 +: 2];

  always_comb begin
    b_v = 4'(beam_y - cfg_sprite_pos_y[b_idx*W_COORD +: W_COORD]);
    b_u = 4'(5'd0 - sprite_bus_postcount[b_idx*5 +: 5]);
    if (!b_ts16) begin
      b_u[3] = 1'b0;
      b_v[3] = 1'b0;
    end
    if (b_flip[0]) b_u = ~b_u & (b_ts16 ? 4'hf : 4'h7);
    if (b_flip[1]) b_v = ~b_v & (b_ts16 ? 4'hf : 4'h7);
    b_tidx = b_ts16 ? {cfg_sprite_tile[b_idx*8 +: 8], b_v, b_u}
                    : {2'b00, cfg_sprite_tile[b_idx*8 +: 8], b_v[2:0], b_u[2:0]};
    b_byte_addr = {cfg_sprite_tsbase, 8'h00} | 32'((20'(b_tidx) << log_pix) >> 3);
  end

  assign b_addr = W_ADDR'(b_byte_addr) & ALIGN_MASK & ADDR_MASK;

  // NOTE: every signal driven here gets a default first, so no path infers a latch.
  always_comb begin
    state_next = state;
    b_load     = 1'b0;
    case (state)
      IDLE: if (b_grant) begin
        state_next = REQ;
        b_load     = 1'b1;
      end
      REQ: if (bus_rdy) begin
        if (b_grant) b_load = 1'b1;
        else         state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Address and grant are frozen while a request is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_oh <= '0;
      bus_addr <= '0;
      ptr_b    <= '0;
    end else if (b_load) begin
      grant_oh <= N_SPRITE'(1) << b_idx;
      bus_addr <= b_addr;
      ptr_b    <= ptr_after(b_idx);
    end
  end

endmodule

// File: tb/tb_riscboy_ppu_sprite_agu_rr.sv
// Directed self-checking bench for riscboy_ppu_sprite_agu_rr with default parameters.
module tb_riscboy_ppu_sprite_agu_rr;

  localparam int N  = 8;
  localparam int WC = 9;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [WC-1:0]   beam_x, beam_y;
  logic [N*WC-1:0] cfg_sprite_pos_x, cfg_sprite_pos_y;
  logic [N*8-1:0]  cfg_sprite_tile;
  logic [N-1:0]    cfg_sprite_tilesize;
  logic [N*2-1:0]  cfg_sprite_flip;
  logic [23:0]     cfg_sprite_tsbase;
  logic [2:0]      cfg_sprite_pixmode;
  logic [N-1:0]    sprite_req, sprite_ack;
  logic            sprite_active, sprite_must_seek;
  logic [WC-1:0]   sprite_x_count;
  logic [4:0]      sprite_shift_seek_target;
  logic [N-1:0]    sprite_bus_vld, sprite_bus_rdy;
  logic [N*5-1:0]  sprite_bus_postcount;
  logic [31:0]     sprite_bus_data;
  logic            bus_vld, bus_rdy;
  logic [31:0]     bus_addr, bus_data;
  logic [1:0]      bus_size;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  riscboy_ppu_sprite_agu_rr dut (
    .clk(clk), .rst_n(rst_n), .beam_x(beam_x), .beam_y(beam_y),
    .cfg_sprite_pos_x(cfg_sprite_pos_x), .cfg_sprite_pos_y(cfg_sprite_pos_y),
    .cfg_sprite_tile(cfg_sprite_tile), .cfg_sprite_tilesize(cfg_sprite_tilesize),
    .cfg_sprite_flip(cfg_sprite_flip), .cfg_sprite_tsbase(cfg_sprite_tsbase),
    .cfg_sprite_pixmode(cfg_sprite_pixmode), .sprite_req(sprite_req), .sprite_ack(sprite_ack),
    .sprite_active(sprite_active), .sprite_x_count(sprite_x_count),
    .sprite_must_seek(sprite_must_seek), .sprite_shift_seek_target(sprite_shift_seek_target),
    .sprite_bus_vld(sprite_bus_vld), .sprite_bus_rdy(sprite_bus_rdy),
    .sprite_bus_postcount(sprite_bus_postcount), .sprite_bus_data(sprite_bus_data),
    .bus_vld(bus_vld), .bus_addr(bus_addr), .bus_size(bus_size),
    .bus_rdy(bus_rdy), .bus_data(bus_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_sprite(input int s, input int px, input int py, input int tile,
                            input int ts16, input int flip, input int post);
    cfg_sprite_pos_x[s*WC +: WC]     = WC'(px);
    cfg_sprite_pos_y[s*WC +: WC]     = WC'(py);
    cfg_sprite_tile[s*8 +: 8]        = 8'(tile);
    cfg_sprite_tilesize[s]           = ts16[0];
    cfg_sprite_flip[s*2 +: 2]        = 2'(flip);
    sprite_bus_postcount[s*5 +: 5]   = 5'(post);
  endtask

  // Single isolated fetch: request, one-cycle issue latency, completion, return to idle.
  task automatic do_fetch(input int s, input logic [31:0] exp_addr, input string tag);
    @(negedge clk);
    sprite_bus_vld[s] = 1'b1;
    bus_rdy = 1'b0;
    #1 check({tag, "_idle_vld"}, bus_vld, 0);
    @(negedge clk);
    #1 check({tag, "_vld"}, bus_vld, 1);
    check({tag, "_addr"}, bus_addr, exp_addr);
    check({tag, "_rdy_wait"}, sprite_bus_rdy, 0);
    bus_rdy  = 1'b1;
    bus_data = 32'hCAFE0000 | 32'(s);
    #1 check({tag, "_rdy"}, sprite_bus_rdy, 64'd1 << s);
    check({tag, "_data"}, sprite_bus_data, 32'hCAFE0000 | 32'(s));
    @(negedge clk);
    sprite_bus_vld[s] = 1'b0;
    bus_rdy = 1'b0;
    #1 check({tag, "_back_idle"}, bus_vld, 0);
  endtask

  task automatic coord_query(input int s);
    @(negedge clk);
    sprite_req[s] = 1'b1;
    @(negedge clk);
    #1 check($sformatf("ack_s%0d", s), sprite_ack, 64'd1 << s);
    sprite_req[s] = 1'b0;
  endtask

  // Requesters may only drop sprite_bus_vld after the edge that completed them.
  logic [N-1:0] pending = '0;
  always @(negedge clk) begin
    #4;
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (pending[i]) begin
          n_cmp++;
          assert (sprite_bus_vld[i]) else begin
            n_err++;
            $error("FAIL vld_held_s%0d: observed 0 expected 1", i);
          end
        end
      end
      pending = sprite_bus_vld & ~sprite_bus_rdy;
    end else begin
      pending = '0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    beam_x = '0; beam_y = 9'd15;
    cfg_sprite_pos_x = '0; cfg_sprite_pos_y = '0; cfg_sprite_tile = '0;
    cfg_sprite_tilesize = '0; cfg_sprite_flip = '0;
    cfg_sprite_tsbase = 24'h000100; cfg_sprite_pixmode = 3'd2;
    sprite_req = '0; sprite_bus_vld = '0; sprite_bus_postcount = '0;
    bus_rdy = 1'b0; bus_data = '0;

    repeat (2) @(negedge clk);
    #1 check("rst_ack", sprite_ack, 0);
    check("rst_bus_vld", bus_vld, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_rdy", sprite_bus_rdy, 0);
    check("rst_active", sprite_active, 0);
    check("rst_x_count", sprite_x_count, 0);
    check("rst_seek", sprite_shift_seek_target, 0);
    check("bus_size", bus_size, 2);
    rst_n = 1'b1;

    // Fetch address: plain, flip Y, flip X, 8bpp, 16 px tile.
    set_sprite(0, 0, 20, 3, 0, 0, 8);
    do_fetch(0, 32'h0001006C, "f_plain");
    cfg_sprite_flip[1:0] = 2'b10;
    do_fetch(0, 32'h00010070, "f_flipy");
    cfg_sprite_flip[1:0] = 2'b01;
    do_fetch(0, 32'h0001006C, "f_flipx");
    cfg_sprite_flip[1:0] = 2'b00;
    set_sprite(1, 0, 20, 3, 0, 0, 8);
    cfg_sprite_pixmode = 3'd1;
    do_fetch(1, 32'h000100D8, "f_8bpp");
    cfg_sprite_pixmode = 3'd2;
    set_sprite(3, 0, 20, 5, 1, 0, 3);
    do_fetch(3, 32'h000102DC, "f_ts16");

    // Back-to-back fair fetches from sprites 0,1,2 (pointer sits past 3, so 0 first).
    begin
      logic [N-1:0] exp_rr [8];
      exp_rr = '{8'h01, 8'h02, 8'h04, 8'h01, 8'h02, 8'h04, 8'h01, 8'h02};
      @(negedge clk);
      sprite_bus_vld[2:0] = 3'b111;
      bus_rdy = 1'b1;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (k == 6) sprite_bus_vld[2] = 1'b0;
        if (k == 7) sprite_bus_vld[0] = 1'b0;
        #1 check($sformatf("rr_fetch_%0d", k), sprite_bus_rdy, exp_rr[k]);
        check($sformatf("rr_fetch_vld_%0d", k), bus_vld, 1);
      end
      @(negedge clk);
      sprite_bus_vld[1] = 1'b0;
      bus_rdy = 1'b0;
      #1 check("rr_fetch_drain", bus_vld, 0);
    end

    // Coordinate queries on sprite 2.
    set_sprite(2, 50, 20, 0, 0, 0, 0);
    beam_x = 9'd45; beam_y = 9'd15;
    coord_query(2);
    check("c45_active", sprite_active, 1);
    check("c45_xcount", sprite_x_count, 5);
    check("c45_seek", sprite_must_seek, 1);
    check("c45_target", sprite_shift_seek_target, 12);
    @(negedge clk);
    #1 check("c_ack_clear", sprite_ack, 0);
    check("c_hold_xcount", sprite_x_count, 5);
    beam_x = 9'd40;
    coord_query(2);
    check("c40_active", sprite_active, 1);
    check("c40_xcount", sprite_x_count, 10);
    check("c40_seek", sprite_must_seek, 0);
    check("c40_target", sprite_shift_seek_target, 24);
    beam_x = 9'd55;
    coord_query(2);
    check("c55_active", sprite_active, 0);
    check("c55_xcount", sprite_x_count, 0);
    check("c55_seek", sprite_must_seek, 1);
    check("c55_target", sprite_shift_seek_target, 0);
    beam_x = 9'd45; beam_y = 9'd20;
    coord_query(2);
    check("cy20_active", sprite_active, 0);
    check("cy20_xcount", sprite_x_count, 5);
    cfg_sprite_tilesize[2] = 1'b1;
    beam_x = 9'd40; beam_y = 9'd5;
    coord_query(2);
    check("c16_active", sprite_active, 1);
    check("c16_seek", sprite_must_seek, 1);
    check("c16_target", sprite_shift_seek_target, 24);

    // Coordinate fairness: ack order 0,1,2.
    @(negedge clk);
    sprite_req[2:0] = 3'b111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 check($sformatf("rr_ack_%0d", k), sprite_ack, 64'd1 << k);
      sprite_req[k] = 1'b0;
    end
    @(negedge clk);
    #1 check("rr_ack_done", sprite_ack, 0);

    // Stall with config churn: address and grant must stay frozen.
    beam_y = 9'd15;
    @(negedge clk);
    sprite_bus_vld[0] = 1'b1;
    @(negedge clk);
    #1 check("stall_addr0", bus_addr, 32'h0001006C);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      cfg_sprite_tile[7:0] = 8'(k + 10);
      sprite_bus_vld[3] = 1'b1;
      #1 check($sformatf("stall_vld_%0d", k), bus_vld, 1);
      check($sformatf("stall_addr_%0d", k), bus_addr, 32'h0001006C);
    end
    @(negedge clk);
    bus_rdy = 1'b1;
    #1 check("stall_rdy", sprite_bus_rdy, 8'h01);
    @(negedge clk);
    sprite_bus_vld[0] = 1'b0;
    bus_rdy = 1'b0;
    sprite_req[3] = 1'b1;
    #1 check("regrant_vld", bus_vld, 1);
    check("regrant_addr", bus_addr, 32'h000102DC);
    check("regrant_rdy_wait", sprite_bus_rdy, 0);

    // Reset in the middle of a request.
    @(negedge clk);
    #1 check("pre_rst_ack", sprite_ack, 8'h08);
    sprite_req[3] = 1'b0;
    bus_rdy = 1'b1;
    #1 check("pre_rst_rdy", sprite_bus_rdy, 8'h08);
    rst_n = 1'b0;
    #1 check("mid_rst_vld", bus_vld, 0);
    check("mid_rst_ack", sprite_ack, 0);
    check("mid_rst_rdy", sprite_bus_rdy, 0);
    check("mid_rst_addr", bus_addr, 0);
    sprite_bus_vld[3] = 1'b0;
    bus_rdy = 1'b0;
    @(negedge clk);
    sprite_bus_vld = 8'h22;
    sprite_req = 8'h24;
    rst_n = 1'b1;
    @(negedge clk);
    bus_rdy = 1'b1;
    #1 check("post_rst_fetch", sprite_bus_rdy, 8'h02);
    check("post_rst_ack", sprite_ack, 8'h04);
    sprite_req[2] = 1'b0;
    @(negedge clk);
    #1 check("post_rst_fetch2", sprite_bus_rdy, 8'h20);
    check("post_rst_ack2", sprite_ack, 8'h20);
    sprite_bus_vld[1] = 1'b0;
    sprite_req[5] = 1'b0;
    @(negedge clk);
    sprite_bus_vld[5] = 1'b0;
    bus_rdy = 1'b0;
    #1 check("post_rst_idle", bus_vld, 0);
    check("post_rst_ack_done", sprite_ack, 0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/riscboy_ppu_sprite_agu_rr.md
Name: riscboy_ppu_sprite_agu_rr

Overview:
Second-generation sprite address-generation unit for the RISCBoy PPU, shared by N_SPRITE sprite pipelines. It answers per-sprite coordinate queries and turns sprite pixel-fetch requests into aligned bus reads. Additions over the first-generation AGU:
- per-sprite tile size and per-sprite X/Y flip;
- round-robin (fair) arbitration on both request ports;
- a registered coordinate response;
- a registered bus request that can issue back-to-back, one fetch per cycle.

Parameters:
W_DATA, 32, bus data width in bits; power of 2, from 8 to 64.
W_ADDR, 32, bus address width.
W_COORD, 9, beam/sprite coordinate width.
N_SPRITE, 8, number of sprite clients, at least 2.
ADDR_MASK, all ones, AND-mask applied to bus_addr.
W_SHIFTCTR, $clog2(W_DATA), derived; width of the seek target.

Ports:
clk  in  1  clock; all state on the rising edge
rst_n  in  1  reset; asynchronous, active-low
beam_x, beam_y  in  W_COORD each  current beam position
cfg_sprite_pos_x, cfg_sprite_pos_y  in  N_SPRITE*W_COORD each  per-sprite bottom-right corner, exclusive
cfg_sprite_tile  in  N_SPRITE*8  per-sprite tile index
cfg_sprite_tilesize  in  N_SPRITE  per sprite: 0 = 8 px tile, 1 = 16 px tile
cfg_sprite_flip  in  N_SPRITE*2  per sprite: bit0 = flip X, bit1 = flip Y
cfg_sprite_tsbase  in  24  tileset base; byte base = tsbase<<8
cfg_sprite_pixmode  in  3  pixel mode; log2 bits/pixel via MODE_LOG_PIXSIZE
sprite_req  in  N_SPRITE  coordinate query request, one bit per sprite
sprite_ack  out  N_SPRITE  registered one-hot; qualifies the coordinate results
sprite_active  out  1  result: sprite is on this line and the beam is left of its right edge
sprite_x_count  out  W_COORD  result: pixels until the right edge
sprite_must_seek  out  1  result: beam is already inside the sprite
sprite_shift_seek_target  out  W_SHIFTCTR  result: initial shift count
sprite_bus_vld  in  N_SPRITE  fetch request per sprite
sprite_bus_rdy  out  N_SPRITE  one-hot fetch completion
sprite_bus_postcount  in  N_SPRITE*5  pixels remaining in the sprite at the fetch point
sprite_bus_data  out  W_DATA  fetch data, equal to bus_data
bus_vld  out  1  bus read request
bus_addr  out  W_ADDR  byte address, aligned to W_DATA
bus_size  out  2  constant log2(W_DATA/8)
bus_rdy  in  1  bus completion
bus_data  in  W_DATA  bus read data

Behaviour:

Reset:
- All registered outputs reset to 0: sprite_ack, all result outputs, bus_vld, bus_addr.
- sprite_bus_rdy = 0. Both round-robin pointers point at sprite 0.
- Reset asserted mid-request drops bus_vld asynchronously. The bus fabric must tolerate this.

Shared definitions (ts = tile size of the sprite concerned):
- ts = 16 if that sprite's tilesize bit is set, else 8.
- Comparisons are done at W_COORD+1 bits, with no wrap.

Coordinate port (latency 1):
- Eligible = sprite_req & ~sprite_ack.
- Each cycle, the round-robin picker grants the lowest eligible index at or after ptr_c. On a grant, ptr_c becomes the granted index + 1, modulo N_SPRITE.
- Results for the granted sprite g are registered, and sprite_ack is set to onehot(g) on the next cycle. If nothing is granted, sprite_ack = 0 and the results hold their previous values.
- Result formulas:
  - intersects_y = beam_y < pos_y && beam_y+ts >= pos_y
  - sprite_active = intersects_y && beam_x < pos_x
  - sprite_x_count = beam_x < pos_x ? pos_x-beam_x : 0
  - sprite_must_seek = beam_x+ts >= pos_x
  - sprite_shift_seek_target = ((ts - x_count[4:0]) << log_pix), truncated to W_SHIFTCTR
- A requester keeps sprite_req high until it sees sprite_ack.

Fetch port, state machine IDLE/REQ:
- Eligible = sprite_bus_vld & ~sprite_bus_rdy.
- IDLE:
  - If any sprite is eligible, grant by round robin on ptr_b.
  - Latch grant_oh and compute the address from the current inputs.
  - Go to REQ with bus_vld=1 on the next cycle.
- REQ:
  - bus_vld=1; bus_addr and grant_oh are held stable until bus_rdy.
  - sprite_bus_rdy = grant_oh & {N{bus_rdy}}, combinational.
  - sprite_bus_data = bus_data.
  - On bus_rdy:
    - If another sprite is eligible (the completing sprite is excluded that cycle), regrant and stay in REQ. This gives one transfer per cycle while bus_rdy stays high.
    - Otherwise go to IDLE.
- A requester must hold sprite_bus_vld and postcount stable until its sprite_bus_rdy. Dropping vld early is illegal; the bench asserts against it.

Fetch address for granted sprite g:
- v = (beam_y - pos_y) mod ts; u = (ts - postcount) mod ts.
- Flip X: u = ts-1-u. Flip Y: v = ts-1-v.
- idx = {tile, v, u}, using 3-bit u,v for 8 px tiles and 4-bit u,v for 16 px tiles.
- bus_addr = ((tsbase<<8) | ((idx<<log_pix)>>3)) & ~(W_DATA/8-1) & ADDR_MASK.
- Configuration changes while in REQ do not affect the latched address.

Test Plan:
1. W_DATA=32, 4bpp, tsbase=0x000100; sprite0: tile 3, size 8, pos_y=20, no flip; beam_y=15, postcount=8 -> bus_addr=0x1006C, bus_vld rises one cycle after vld, sprite_bus_rdy[0] in the bus_rdy cycle.
2. Same as 1 with flip Y -> bus_addr=0x10070. With flip X and postcount=8 -> u=7, bus_addr=0x1006C (word-aligned).
3. Coordinate query on sprite2: pos_x=50, pos_y=20, size 8, 4bpp; beam 45,15 -> one cycle later: ack=0b100, active=1, x_count=5, must_seek=1, seek_target=12. With beam_x=40 -> x_count=10, must_seek=0.
4. Sprites 0, 1, 2 hold bus vld continuously, bus_rdy=1 -> grant order 0,1,2,0,1,2 with one completion per cycle and no idle cycles. Same fairness check on sprite_req: ack order 0,1,2.
5. bus_rdy held low for 5 cycles while cfg_sprite_tile changes -> bus_addr and bus_vld stable throughout; rdy is delivered to the original sprite only.
6. rst_n asserted mid-REQ -> bus_vld, sprite_ack, sprite_bus_rdy go to 0 immediately. After release, the first grant goes to the lowest-indexed eligible sprite.
